// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - polyphonic voice allocator, beat-duration tracker and saturating sample mixer
// Optional macro VOICE_STEAL_EN: when every voice is busy, steal the one with the least remaining duration.
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int DUR_W      = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic [5:0]               note_in,
    input  logic [19:0]              freq,
    input  logic [DUR_W-1:0]         duration,
    input  logic                     beat,
    input  logic                     generate_next,
    output logic [NUM_VOICES-1:0]    voice_load,
    output logic [5:0]               voice_note,
    output logic [19:0]              voice_freq,
    output logic [NUM_VOICES-1:0]    voice_done,
    output logic [NUM_VOICES-1:0]    voice_gen,
    input  logic [NUM_VOICES-1:0]    voice_ready,
    input  logic [16*NUM_VOICES-1:0] voice_sample,
    output logic [NUM_VOICES-1:0]    busy,
    output logic                     mix_valid,
    output logic [15:0]              mix_sample,
    output logic                     overrun
);
    localparam logic [0:0] A_IDLE    = 1'b0;
    localparam logic [0:0] A_LOAD    = 1'b1;
    localparam logic [1:0] M_IDLE    = 2'd0;
    localparam logic [1:0] M_COLLECT = 2'd1;
    localparam logic [1:0] M_OUT     = 2'd2;
    localparam logic [DUR_W-1:0] ONE = DUR_W'(1);

    logic [0:0]            a_state;
    logic [1:0]            m_state;
    logic [DUR_W-1:0]      count   [NUM_VOICES];
    logic [15:0]           latched [NUM_VOICES];
    logic [NUM_VOICES-1:0] expected, got, got_next, sel;
    logic                  found, accept;
    logic [DUR_W-1:0]      load_count;
    logic [18:0]           sum;
    logic [15:0]           sat_sum;
`ifdef VOICE_STEAL_EN
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    logic [IDX_W-1:0]      best;
    logic                  steal;
`endif

    // Voice selection: lowest-index free voice, or a stolen voice when stealing is enabled.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!busy[v] && !found) begin
                sel[v] = 1'b1;
                found  = 1'b1;
            end
        end
`ifdef VOICE_STEAL_EN
        best  = '0;
        steal = 1'b0;
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (count[v] < count[best]) best = IDX_W'(v);
        end
        if (!found) begin
            sel[best] = 1'b1;
            steal     = 1'b1;
        end
        note_ready = (a_state == A_IDLE);
`else
        note_ready = (a_state == A_IDLE) && found;
`endif
        accept     = note_valid && note_ready;
        load_count = (duration == '0) ? ONE : duration;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_state    <= A_IDLE;
            voice_load <= '0;
            voice_note <= '0;
            voice_freq <= '0;
            voice_done <= '0;
            busy       <= '0;
            for (int v = 0; v < NUM_VOICES; v++) count[v] <= '0;
        end else begin
            a_state    <= accept ? A_LOAD : A_IDLE;
            voice_load <= accept ? sel : '0;
            voice_done <= '0;
            if (accept) begin
                voice_note <= note_in;
                voice_freq <= freq;
            end
            // A load into a voice takes precedence over a coincident beat decrement.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (accept && sel[v]) begin
                    busy[v]  <= 1'b1;
                    count[v] <= load_count;
`ifdef VOICE_STEAL_EN
                    voice_done[v] <= steal;
`endif
                end else if (beat && busy[v]) begin
                    count[v] <= count[v] - ONE;
                    if (count[v] == ONE) begin
                        busy[v]       <= 1'b0;
                        voice_done[v] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        got_next = got | (voice_ready & expected);
        sum      = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (expected[v]) sum = sum + {{3{latched[v][15]}}, latched[v]};
        end
        if (sum[18:15] == 4'b0000 || sum[18:15] == 4'b1111) sat_sum = sum[15:0];
        else                                                 sat_sum = sum[18] ? 16'h8000 : 16'h7FFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state    <= M_IDLE;
            expected   <= '0;
            got        <= '0;
            voice_gen  <= '0;
            mix_valid  <= 1'b0;
            mix_sample <= '0;
            overrun    <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) latched[v] <= '0;
        end else begin
            voice_gen <= '0;
            mix_valid <= 1'b0;
            if (generate_next) begin
                if (m_state != M_IDLE) overrun <= 1'b1;
                voice_gen <= busy;
                expected  <= busy;
                got       <= '0;
                m_state   <= M_COLLECT;
            end else begin
                case (m_state)
                    M_COLLECT: begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (voice_ready[v] && expected[v]) latched[v] <= voice_sample[16*v +: 16];
                        end
                        got <= got_next;
                        if (got_next == expected) m_state <= M_OUT;
                    end
                    M_OUT: begin
                        mix_valid  <= 1'b1;
                        mix_sample <= sat_sum;
                        m_state    <= M_IDLE;
                    end
                    default: m_state <= M_IDLE;
                endcase
            end
        end
    end
endmodule
